// File: rtl/button_pc_sequencer.sv
// Program-counter sequencer: debounces frame-sampled push buttons and turns
// clear / step / run-stop presses into a PC address for the instruction ROM.
module button_pc_sequencer #(
  parameter int PC_WIDTH        = 8,
  parameter int PC_MAX          = 255,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int RUN_DIV         = 5000000
) (
  input  logic                i_CLK,
  input  logic                i_SYS_RESET,
  input  logic                i_FRAME_VALID,
  input  logic                i_BTN_CLR,
  input  logic                i_BTN_STEP,
  input  logic                i_BTN_RUN,
  output logic [PC_WIDTH-1:0] o_PC,
  output logic                o_PC_STROBE,
  output logic                o_RUNNING,
  output logic                o_WRAP
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  localparam logic [15:0]         DB_LAST  = 16'(DEBOUNCE_FRAMES - 1);
  localparam logic [23:0]         DIV_LAST = 24'(RUN_DIV - 1);
  localparam logic [PC_WIDTH-1:0] PC_LAST  = PC_WIDTH'(PC_MAX);

  // Bit order: 0 = clear, 1 = step, 2 = run/stop.
  logic [2:0] raw_btn;
  logic [2:0] press_bus;

  assign raw_btn = {i_BTN_RUN, i_BTN_STEP, i_BTN_CLR};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic [15:0] cnt_reg;
      logic [15:0] cnt_next;
      logic        stable_reg;
      logic        stable_next;
      logic        press_reg;
      logic        press_next;

      // Counter only moves on frame strobes; a matching sample restarts it.
      always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        press_next  = 1'b0;
        if (i_FRAME_VALID) begin
          if (raw_btn[gi] != stable_reg) begin
            if (cnt_reg == DB_LAST) begin
              stable_next = ~stable_reg;
              cnt_next    = 16'd0;
              press_next  = ~stable_reg;
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end else begin
            cnt_next = 16'd0;
          end
        end
      end

      always_ff @(posedge i_CLK) begin
        if (i_SYS_RESET) begin
          cnt_reg    <= 16'd0;
          stable_reg <= 1'b0;
          press_reg  <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          stable_reg <= stable_next;
          press_reg  <= press_next;
        end
      end

      assign press_bus[gi] = press_reg;
    end
  endgenerate

  logic [0:0]          state_reg;
  logic [0:0]          state_next;
  logic [23:0]         presc_reg;
  logic [23:0]         presc_next;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  logic                strobe_reg;
  logic                strobe_next;
  logic                wrap_reg;
  logic                wrap_next;
  logic                tick;

  assign tick = (state_reg == STATE_RUN) && (presc_reg == DIV_LAST);

  // Clear beats run/stop, which beats step/tick; a run toggle swallows both.
  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    pc_next     = pc_reg;
    strobe_next = 1'b0;
    wrap_next   = 1'b0;
    if (press_bus[0]) begin
      pc_next     = '0;
      strobe_next = (pc_reg != '0);
      state_next  = STATE_IDLE;
      presc_next  = 24'd0;
    end else if (press_bus[2]) begin
      state_next = ~state_reg;
      presc_next = 24'd0;
    end else begin
      if (state_reg == STATE_RUN) begin
        presc_next = tick ? 24'd0 : presc_reg + 24'd1;
      end
      if ((press_bus[1] && state_reg == STATE_IDLE) || tick) begin
        strobe_next = 1'b1;
        if (pc_reg == PC_LAST) begin
          pc_next   = '0;
          wrap_next = 1'b1;
        end else begin
          pc_next = pc_reg + PC_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_SYS_RESET) begin
      state_reg  <= STATE_IDLE;
      presc_reg  <= 24'd0;
      pc_reg     <= '0;
      strobe_reg <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      pc_reg     <= pc_next;
      strobe_reg <= strobe_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign o_PC        = pc_reg;
  assign o_PC_STROBE = strobe_reg;
  assign o_RUNNING   = (state_reg == STATE_RUN);
  assign o_WRAP      = wrap_reg;

endmodule

// File: tb/tb_button_pc_sequencer.sv
// Bench for button_pc_sequencer: table of button presses, hand-built timing
// corners, then random buttons compared cycle by cycle with a behavioural model.
module tb_button_pc_sequencer;

  localparam int PC_WIDTH = 8;
  localparam int PC_MAX   = 5;
  localparam int DEB      = 4;
  localparam int RUN_DIV  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                fv = 1'b0;
  logic                b_clr = 1'b0;
  logic                b_step = 1'b0;
  logic                b_run = 1'b0;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_strobe;
  logic                running;
  logic                wrap;

  always #5 clk = ~clk;

  button_pc_sequencer #(
    .PC_WIDTH(PC_WIDTH), .PC_MAX(PC_MAX), .DEBOUNCE_FRAMES(DEB), .RUN_DIV(RUN_DIV)
  ) dut (
    .i_CLK(clk), .i_SYS_RESET(rst), .i_FRAME_VALID(fv),
    .i_BTN_CLR(b_clr), .i_BTN_STEP(b_step), .i_BTN_RUN(b_run),
    .o_PC(pc), .o_PC_STROBE(pc_strobe), .o_RUNNING(running), .o_WRAP(wrap)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference state
  int m_pc;
  bit m_run;
  int m_presc;
  bit m_strobe;
  bit m_wrap;
  bit m_stable[3];
  int m_cnt[3];
  bit m_ev[3];

  int cyc = 0;
  int strobe_log[$];
  int wrap_count = 0;
  int rise_time = -1;
  bit prev_running = 1'b0;

  typedef struct {
    int btn;
    int hi;
    int lo;
    int exp_pc;
    int exp_strobes;
    int exp_wraps;
  } vec_t;

  vec_t vecs[10];

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit f, input bit bc, input bit bs, input bit br);
    bit smp[3];
    bit new_ev[3];
    bit tk;
    if (r) begin
      m_pc = 0; m_run = 0; m_presc = 0; m_strobe = 0; m_wrap = 0;
      for (int i = 0; i < 3; i++) begin
        m_stable[i] = 0; m_cnt[i] = 0; m_ev[i] = 0;
      end
      return;
    end
    tk = m_run && (m_presc == RUN_DIV - 1);
    m_strobe = 0;
    m_wrap = 0;
    if (m_ev[0]) begin
      m_strobe = (m_pc != 0);
      m_pc = 0; m_run = 0; m_presc = 0;
    end else if (m_ev[2]) begin
      m_run = !m_run;
      m_presc = 0;
    end else begin
      if (m_run) m_presc = (m_presc + 1) % RUN_DIV;
      if ((m_ev[1] && !m_run) || tk) begin
        m_strobe = 1;
        m_wrap = (m_pc == PC_MAX);
        m_pc = (m_pc + 1) % (PC_MAX + 1);
      end
    end
    smp[0] = bc; smp[1] = bs; smp[2] = br;
    for (int i = 0; i < 3; i++) begin
      new_ev[i] = 0;
      if (f) begin
        if (smp[i] != m_stable[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_stable[i] = !m_stable[i];
            m_cnt[i] = 0;
            new_ev[i] = m_stable[i];
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
    m_ev = new_ev;
  endtask

  task automatic step_cycle(input bit r, input bit f, input bit bc, input bit bs, input bit br);
    rst = r; fv = f; b_clr = bc; b_step = bs; b_run = br;
    @(posedge clk);
    model_step(r, f, bc, bs, br);
    #1;
    cyc++;
    if (pc_strobe) strobe_log.push_back(cyc);
    if (wrap) wrap_count++;
    if (running && !prev_running) rise_time = cyc;
    prev_running = running;
    check_int("pc", int'(pc), m_pc);
    check_int("strobe", int'(pc_strobe), int'(m_strobe));
    check_int("running", int'(running), int'(m_run));
    check_int("wrap", int'(wrap), int'(m_wrap));
  endtask

  task automatic frame(input bit bc, input bit bs, input bit br);
    step_cycle(0, 1, bc, bs, br);
    step_cycle(0, 0, bc, bs, br);
  endtask

  task automatic press(input int btn, input int hi, input int lo);
    for (int i = 0; i < hi; i++) frame(btn == 0, btn == 1, btn == 2);
    for (int i = 0; i < lo; i++) frame(0, 0, 0);
  endtask

  initial begin
    int s0;
    int w0;
    int n;
    int d;
    bit rb[3];

    vecs[0] = '{1, 4, 4, 1, 1, 0};
    vecs[1] = '{1, 3, 4, 1, 0, 0};
    vecs[2] = '{1, 4, 4, 2, 1, 0};
    vecs[3] = '{1, 4, 4, 3, 1, 0};
    vecs[4] = '{1, 4, 4, 4, 1, 0};
    vecs[5] = '{1, 4, 4, 5, 1, 0};
    vecs[6] = '{1, 4, 4, 0, 1, 1};
    vecs[7] = '{0, 4, 4, 0, 0, 0};
    vecs[8] = '{1, 4, 4, 1, 1, 0};
    vecs[9] = '{0, 4, 4, 0, 1, 0};

    // Reset held three cycles, then released
    for (int i = 0; i < 3; i++) begin
      step_cycle(1, 0, 0, 0, 0);
      check_int("reset_strobe", int'(pc_strobe), 0);
    end
    for (int i = 0; i < 2; i++) step_cycle(0, 0, 0, 0, 0);
    check_int("reset_pc", int'(pc), 0);
    check_int("reset_running", int'(running), 0);
    check_int("reset_no_strobes", strobe_log.size(), 0);
    $display("reset: pc=%0d running=%0d", pc, running);

    // Table of single-button presses from idle
    foreach (vecs[v]) begin
      s0 = strobe_log.size();
      w0 = wrap_count;
      press(vecs[v].btn, vecs[v].hi, vecs[v].lo);
      check_int("vec_pc", int'(pc), vecs[v].exp_pc);
      check_int("vec_strobes", strobe_log.size() - s0, vecs[v].exp_strobes);
      check_int("vec_wraps", wrap_count - w0, vecs[v].exp_wraps);
      $display("vec %0d: btn=%0d hi=%0d lo=%0d -> pc=%0d strobes=%0d wraps=%0d",
               v, vecs[v].btn, vecs[v].hi, vecs[v].lo, pc,
               strobe_log.size() - s0, wrap_count - w0);
    end

    // Run mode: cadence survives a step press, second run press stops it
    press(2, 4, 4);
    check_int("run_on", int'(running), 1);
    strobe_log.delete();
    press(1, 4, 4);
    for (int i = 0; i < 8; i++) frame(0, 0, 0);
    check_int("cadence_count_ok", int'(strobe_log.size() >= 3), 1);
    for (int i = 1; i < strobe_log.size(); i++)
      check_int("cadence_interval", strobe_log[i] - strobe_log[i-1], RUN_DIV);
    $display("run: %0d advances, pc=%0d", strobe_log.size(), pc);
    press(2, 4, 4);
    check_int("run_off", int'(running), 0);
    strobe_log.delete();
    for (int i = 0; i < 12; i++) frame(0, 0, 0);
    check_int("stopped_strobes", strobe_log.size(), 0);
    $display("stop: running=%0d pc=%0d", running, pc);

    // Clear press landing on the same edge as a prescaler tick at pc=3
    press(2, 4, 4);
    for (int i = 0; i < 3; i++) frame(1, 0, 0);
    n = 0;
    while (!(m_pc == 3 && m_presc == RUN_DIV - 2) && n < 200) begin
      step_cycle(0, 0, 1, 0, 0);
      n++;
    end
    check_int("clr_align_in_budget", int'(n < 200), 1);
    step_cycle(0, 1, 1, 0, 0);
    step_cycle(0, 0, 1, 0, 0);
    check_int("clr_tick_pc", int'(pc), 0);
    check_int("clr_tick_strobe", int'(pc_strobe), 1);
    check_int("clr_tick_wrap", int'(wrap), 0);
    check_int("clr_tick_running", int'(running), 0);
    $display("clr+tick: pc=%0d strobe=%0d wrap=%0d running=%0d", pc, pc_strobe, wrap, running);
    for (int i = 0; i < 4; i++) frame(0, 0, 0);

    // Reset landing on a tick edge; prescaler must restart on next run
    press(2, 4, 4);
    n = 0;
    while (m_presc != RUN_DIV - 1 && n < 50) begin
      step_cycle(0, 0, 0, 0, 0);
      n++;
    end
    check_int("rst_align_in_budget", int'(n < 50), 1);
    step_cycle(1, 0, 0, 0, 0);
    check_int("rst_tick_pc", int'(pc), 0);
    check_int("rst_tick_strobe", int'(pc_strobe), 0);
    check_int("rst_tick_running", int'(running), 0);
    for (int i = 0; i < 3; i++) begin
      step_cycle(0, 0, 0, 0, 0);
      check_int("post_rst_strobe", int'(pc_strobe), 0);
    end
    strobe_log.delete();
    press(2, 4, 4);
    for (int i = 0; i < 6; i++) frame(0, 0, 0);
    d = (strobe_log.size() > 0) ? strobe_log[0] - rise_time : -1;
    check_int("restart_first_tick", d, RUN_DIV);
    $display("reset-in-run: first advance %0d cycles after run start", d);

    // Random buttons, frames and occasional resets against the model
    rb[0] = 0; rb[1] = 0; rb[2] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 11) == 0) rb[k] = !rb[k];
      step_cycle(($urandom_range(0, 599) == 0), 1'($urandom_range(0, 1)), rb[0], rb[1], rb[2]);
    end
    $display("random: 3000 cycles, pc=%0d running=%0d", pc, running);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_pc_sequencer.md
Name: button_pc_sequencer

Overview:
Program-counter sequencer feeding the instruction-memory address port that drives the LED PISO chain. It samples raw push-button bits taken from the DIP/button SIPO frame and debounces them per frame. It converts presses into clear, single-step and run/stop commands. In run mode it generates the PC address that the instruction ROM uses to drive the LEDs, and it reports PC changes for the seven-segment display.

Parameters:
PC_WIDTH, 8, width of o_PC (ROM address width)
PC_MAX, 255, last valid PC value; PC wraps from PC_MAX to 0
DEBOUNCE_FRAMES, 4, consecutive valid frames a button sample must disagree with its stable value before the stable value flips; legal range 1 to 65535
RUN_DIV, 5000000, clock cycles per automatic PC advance in run mode (1 Hz at 5 MHz); legal range 2 to 2^24-1

Ports:
i_CLK  input  1  system clock (PSCLK domain, 5 MHz)
i_SYS_RESET  input  1  synchronous reset, active-high
i_FRAME_VALID  input  1  one-cycle strobe: button bits below hold a fresh SIPO frame
i_BTN_CLR  input  1  raw clear button bit from SIPO frame
i_BTN_STEP  input  1  raw step button bit
i_BTN_RUN  input  1  raw run/stop toggle button bit
o_PC  output  PC_WIDTH  current program counter / ROM address
o_PC_STROBE  output  1  one-cycle pulse in the cycle o_PC first shows a new value
o_RUNNING  output  1  high while in RUN state
o_WRAP  output  1  one-cycle pulse coincident with o_PC_STROBE when PC wraps PC_MAX->0

Behaviour:
- One clock (i_CLK). Reset is synchronous and active-high on i_SYS_RESET. All state updates on posedge i_CLK.
- Reset values: o_PC=0, o_PC_STROBE=0, o_RUNNING=0, o_WRAP=0. All debounce stable values=0, debounce counters=0, prescaler=0, state=IDLE.
- Reset asserted mid-operation overrides everything in that cycle, including pending presses and prescaler ticks.
- Debounce, per button:
  - Button bits are sampled only in cycles where i_FRAME_VALID=1.
  - If sample != stable, the counter increments. When it reaches DEBOUNCE_FRAMES, stable flips and the counter clears.
  - If sample == stable, the counter clears.
  - Bits are ignored while i_FRAME_VALID=0, and the counter holds.
- Press event: a 0->1 transition of the stable value. The event is a one-cycle internal pulse in the cycle after the flip. Releases generate nothing.
- States: IDLE (stepping) and RUN (auto).
  - IDLE -> RUN on a RUN press. RUN -> IDLE on a RUN press or a CLR press.
  - Entering RUN clears the prescaler.
- Prescaler: counts only in RUN, 0..RUN_DIV-1. At RUN_DIV-1 it issues a tick and returns to 0.
- PC update priority within one cycle (highest first):
  1. CLR press: o_PC<=0, state<=IDLE, prescaler<=0. o_PC_STROBE pulses only if o_PC was nonzero; o_WRAP=0.
  2. RUN press: toggles state only. A STEP press or tick in the same cycle is dropped.
  3. STEP press in IDLE, or tick in RUN: advance the PC.
- STEP press in RUN is ignored.
- Advance: if o_PC==PC_MAX then o_PC<=0 and o_WRAP=1, else o_PC<=o_PC+1. Arithmetic is unsigned, PC_WIDTH bits; PC_MAX < 2^PC_WIDTH.
- Latency:
  - Stable flip to press event: 1 cycle.
  - Press event to new o_PC and o_PC_STROBE: 1 cycle.
  - Tick to new o_PC: 1 cycle.
- o_PC_STROBE and o_WRAP are registered and last exactly one cycle.
- o_RUNNING is the registered state bit.

Test Plan:
Run with DEBOUNCE_FRAMES=4, RUN_DIV=8, PC_MAX=5, and i_FRAME_VALID pulsed every 2 cycles.
- Reset hold 3 cycles, then release -> o_PC=0, o_RUNNING=0, no strobes during or after reset.
- STEP high for 4 frames then low for 4 frames -> o_PC 0->1, exactly one o_PC_STROBE.
- STEP glitch high for 3 frames then low -> o_PC unchanged, no strobe.
- Six clean STEP presses from 0 -> o_PC sequence 1,2,3,4,5,0. o_WRAP pulses only on 5->0, together with o_PC_STROBE.
- RUN press -> o_RUNNING=1; o_PC advances every 8 cycles. A STEP press during RUN leaves the cadence unchanged. A second RUN press sets o_RUNNING=0 and stops advancing.
- In RUN with o_PC=3: CLR press in the same cycle as a prescaler tick -> o_PC=0, o_RUNNING=0, one strobe, o_WRAP=0.
- In RUN: assert i_SYS_RESET one cycle before a tick -> o_PC=0, o_RUNNING=0, no strobe, and the prescaler restarts from 0.
